// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared constants for the seven-segment scan controller.
package seg7_scan_ctrl_pkg;

    // All segments and decimal point off (active-low outputs).
    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Hex digit to active-low {g,f,e,d,c,b,a}; index 0 is the rightmost entry.
    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'h0E,  // F
        7'h06,  // E
        7'h21,  // d
        7'h46,  // C
        7'h03,  // b
        7'h08,  // A
        7'h10,  // 9
        7'h00,  // 8
        7'h78,  // 7
        7'h02,  // 6
        7'h12,  // 5
        7'h19,  // 4
        7'h30,  // 3
        7'h24,  // 2
        7'h79,  // 1
        7'h40   // 0
    };

    // Width of the scan index for n digits, never less than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg7_scan_ctrl_hex7seg.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex7seg
    import seg7_scan_ctrl_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg_n
);

    assign seg_n = HEX_SEG_TABLE[hex];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed seven-segment driver with frame-aligned double buffering.
module seg7_scan_ctrl
    import seg7_scan_ctrl_pkg::*;
#(
    parameter int unsigned DIGITS    = 8,
    parameter int unsigned SCAN_BIT  = 17,
    parameter int unsigned BLINK_BIT = 25
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           clkdiv,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   disp_data,
    input  logic [DIGITS-1:0]     point_in,
    input  logic [DIGITS-1:0]     blank_in,
    input  logic [DIGITS-1:0]     blink_in,
    output logic [DIGITS-1:0]     an,
    output logic [7:0]            seg,
    output logic                  pending,
    output logic                  frame_done
);

    localparam int unsigned      IDX_W    = idx_width(DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    logic scan_s1, scan_s2, scan_prev;
    logic blink_s1, blink_s2;
    logic tick, wrap;

    logic [IDX_W-1:0] idx, idx_next;

    logic [4*DIGITS-1:0] stage_data, act_data, data_nx;
    logic [DIGITS-1:0]   stage_point, act_point, point_nx;
    logic [DIGITS-1:0]   stage_blank, act_blank, blank_nx;
    logic [DIGITS-1:0]   stage_blink, act_blink, blink_nx;

    logic [3:0]          nibble;
    logic [6:0]          dec_seg;
    logic                dp_on;
    logic                digit_off;
    logic [DIGITS-1:0]   an_nx;

    // Only two divider taps are consumed; the rest are deliberately ignored.
    logic clkdiv_unused;
    assign clkdiv_unused = ^clkdiv;

    assign tick     = scan_s2 & ~scan_prev;
    assign wrap     = tick && (idx == LAST_IDX);
    assign idx_next = wrap ? '0 : idx + IDX_W'(1);

    // The set visible after this tick: staging if the tick commits, else active.
    assign data_nx  = wrap ? stage_data  : act_data;
    assign point_nx = wrap ? stage_point : act_point;
    assign blank_nx = wrap ? stage_blank : act_blank;
    assign blink_nx = wrap ? stage_blink : act_blink;

    // Two-flop synchronisers for the divider taps plus edge-detect history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_s1   <= 1'b0;
            scan_s2   <= 1'b0;
            scan_prev <= 1'b0;
            blink_s1  <= 1'b0;
            blink_s2  <= 1'b0;
        end else begin
            scan_s1   <= clkdiv[SCAN_BIT];
            scan_s2   <= scan_s1;
            scan_prev <= scan_s2;
            blink_s1  <= clkdiv[BLINK_BIT];
            blink_s2  <= blink_s1;
        end
    end

    // Scan index, frame pulse, staging capture and frame-boundary commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx         <= '0;
            frame_done  <= 1'b0;
            pending     <= 1'b0;
            stage_data  <= '0;
            stage_point <= '0;
            stage_blank <= '0;
            stage_blink <= '0;
            act_data    <= '0;
            act_point   <= '0;
            act_blank   <= '0;
            act_blink   <= '0;
        end else begin
            frame_done <= wrap;
            if (tick) begin
                idx <= idx_next;
            end
            if (wrap) begin
                act_data  <= stage_data;
                act_point <= stage_point;
                act_blank <= stage_blank;
                act_blink <= stage_blink;
            end
            // A load on the commit tick refills staging after the old set moved out.
            if (load) begin
                stage_data  <= disp_data;
                stage_point <= point_in;
                stage_blank <= blank_in;
                stage_blink <= blink_in;
                pending     <= 1'b1;
            end else if (wrap) begin
                pending     <= 1'b0;
            end
        end
    end

    // Select the fields of the digit about to be shown.
    always_comb begin
        nibble    = '0;
        dp_on     = 1'b0;
        digit_off = 1'b0;
        an_nx     = '1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx_next == i[IDX_W-1:0]) begin
                nibble    = data_nx[4*i +: 4];
                dp_on     = point_nx[i];
                digit_off = blank_nx[i] | (blink_nx[i] & ~blink_s2);
                an_nx[i]  = 1'b0;
            end
        end
        if (digit_off) begin
            an_nx = '1;
        end
    end

    hex7seg u_hex7seg (
        .hex   (nibble),
        .seg_n (dec_seg)
    );

    // Registered display outputs, refreshed only on scan ticks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= '1;
            seg <= SEG_OFF;
        end else if (tick) begin
            an  <= an_nx;
            seg <= {~dp_on, dec_seg};
        end
    end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Downstream consumer of the clock divider's free-running `clkdiv` bus.
- Time-multiplexes a DIGITS-wide hex value onto a common-anode seven-segment display, with per-digit decimal point, blanking and blink.
- New data is double-buffered and committed only at a frame boundary, so a digit never shows torn data.
- Runs entirely on `clk`. `clkdiv` taps are synchronised and edge-detected into enables; they are never used as clocks.

Parameters:
- DIGITS, 8, number of digits scanned (legal range 1..8).
- SCAN_BIT, 17, `clkdiv` bit whose rising edge advances the scan.
- BLINK_BIT, 25, `clkdiv` bit giving the blink phase (1 = lit).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- clkdiv  in  32  divider count from the clock divider stage.
- load  in  1  one-cycle strobe that captures the display inputs.
- disp_data  in  4*DIGITS  hex nibbles; digit i = disp_data[4i+3:4i].
- point_in  in  DIGITS  decimal point enable per digit.
- blank_in  in  DIGITS  digit forced off.
- blink_in  in  DIGITS  digit blinks with the blink phase.
- an  out  DIGITS  anode selects, active-low.
- seg  out  8  segments, active-low, {dp,g,f,e,d,c,b,a}.
- pending  out  1  staged data not yet committed.
- frame_done  out  1  one-cycle pulse at each frame wrap.

Behaviour:
- Reset values (asynchronous, all registers):
  - an = all ones, seg = 8'hFF, pending = 0, frame_done = 0.
  - idx = 0; staging and active registers = 0; sync flops = 0.
- Synchronisers:
  - clkdiv[SCAN_BIT] and clkdiv[BLINK_BIT] each pass through a 2-flop synchroniser.
  - A third flop on the scan path gives tick = sync & ~prev: a single-clk pulse per rising edge.
- Scan counter:
  - idx is ceil(log2(DIGITS)) bits wide, minimum 1.
  - Increments on tick; wraps DIGITS-1 -> 0.
  - frame_done = 1 in the cycle after a tick that wraps idx.
- Staging:
  - load = 1 captures disp_data, point_in, blank_in and blink_in into staging registers and sets pending = 1.
  - Repeated loads before commit overwrite staging; last load wins.
- Commit:
  - Occurs on the wrapping tick: staging -> active, pending -> 0.
  - If load coincides with the commit tick, the old staging commits first, the new data is captured, and pending stays 1.
- Output stage (registered, 1 clk after tick; holds between ticks):
  - an[idx] = 0 and all other an bits = 1, unless active blank[idx] = 1, or active blink[idx] = 1 while blink phase = 0. In those cases an = all ones.
  - seg[6:0] = decode(active nibble idx), active-low.
  - seg[7] = ~active point[idx].
  - The output stage uses the already-updated idx and the active set, including a set committed on that same tick.
- Decode table (dp off): 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E.
- Reset mid-operation: outputs blank immediately (asynchronous) and staged data is discarded. The scan resumes from idx 0 after release.
- No combinational path from any input to an or seg.

Decomposition:
- Shared package holds:
  - SEG_OFF = 8'hFF.
  - The 16-entry hex-to-segment constant table.
  - Localparam helper for the idx width.
- One sub-module: hex7seg, a purely combinational 4-bit to 7-bit active-low decoder built from the table.
- Synchroniser, scan counter, double buffer and output registers stay in seg7_scan_ctrl.

Test Plan:
1. Reset -> an = FF, seg = FF, pending = 0, frame_done = 0. Toggling clkdiv with no load shows digit 0 as C0 on an = FE.
2. Load 32'h01234567 at idx 0, then drive scan ticks:
   - pending = 1 until the wrap, where frame_done pulses and pending falls.
   - Next frame: an = FE/seg = F8, an = FD/seg = 82, ... , an = 7F/seg = C0.
3. Load at idx 3 mid-frame -> an/seg remain the old data until idx wraps. A second load before the wrap -> only the second value is displayed.
4. Load asserted in the same cycle as the wrapping tick -> the previous staging is displayed, pending stays 1, and the new value appears one frame later.
5. Decimal point, blink and blank:
   - point_in[0] = 1 with digit 0 = 8 -> seg = 00.
   - blink_in[2] = 1: with clkdiv[25] = 0, an stays FF during slot 2; with clkdiv[25] = 1, an = FB.
   - blank_in[5] = 1 -> an = FF during slot 5.
6. Assert rst at idx 5 -> an = FF, seg = FF and pending = 0 in the same cycle. After release, the first tick drives slot 1 (an = FD) with active data = 0.
